// File: rtl/exe_feed_reg_pkg.sv
// ============================================================================
// Module  : exe_feed_reg_pkg
// Brief   : Shared ALU command codes, status bit indices and EXE control type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_feed_reg_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Status register layout {Z,C,N,V}
    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

    typedef struct packed {
        logic wb_en;
        logic mem_r;
        logic mem_w;
        logic s;
    } exe_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
// Module  : fwd_mux
// Brief   : Operand forwarding select, MEM producer over WB over register copy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_mux
    import exe_feed_reg_pkg::*;
(
    input  logic        fwd_en,
    input  logic [3:0]  src,
    input  logic [31:0] reg_val,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic        wb_wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic [31:0] val
);

    always_comb begin
        val = reg_val;
        if (fwd_en) begin
            // MEM holds the younger result, so it beats WB on a double match
            if (mem_wb_en && (mem_dest == src)) begin
                val = mem_result;
            end else if (wb_wb_en && (wb_dest == src)) begin
                val = wb_value;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/exe_feed_reg.sv
// ============================================================================
// Module  : exe_feed_reg
// Brief   : ID/EXE pipeline register with operand forwarding and status flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_feed_reg
    import exe_feed_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [3:0]  id_exe_cmd,
    input  logic        id_s,
    input  logic        id_imm,
    input  logic [31:0] id_val1,
    input  logic [31:0] id_val2,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic [3:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_r,
    input  logic        id_mem_w,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic        wb_wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic [3:0]  alu_sr,
    output logic        exe_valid,
    output logic [3:0]  exe_cmd,
    output logic [31:0] val1,
    output logic [31:0] val2,
    output logic        cin,
    output logic [3:0]  exe_dest,
    output logic        exe_wb_en,
    output logic        exe_mem_r,
    output logic        exe_mem_w,
    output logic [3:0]  status
);

    logic        r_valid;
    logic [3:0]  r_cmd;
    exe_ctrl_t   r_ctrl;
    logic        r_imm;
    logic [31:0] r_val1;
    logic [31:0] r_val2;
    logic [3:0]  r_src1;
    logic [3:0]  r_src2;
    logic [3:0]  r_dest;
    logic [3:0]  r_status;
    logic        w_status_load;

    // A squash or stall in this cycle must not let the EXE instruction commit flags
    assign w_status_load = r_valid & r_ctrl.s & ~freeze & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_cmd    <= 4'd0;
            r_ctrl   <= '0;
            r_imm    <= 1'b0;
            r_val1   <= 32'd0;
            r_val2   <= 32'd0;
            r_src1   <= 4'd0;
            r_src2   <= 4'd0;
            r_dest   <= 4'd0;
            r_status <= 4'd0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (!freeze) begin
                r_valid <= id_valid;
                r_cmd   <= id_exe_cmd;
                r_imm   <= id_imm;
                r_val1  <= id_val1;
                r_val2  <= id_val2;
                r_src1  <= id_src1;
                r_src2  <= id_src2;
                r_dest  <= id_dest;
                r_ctrl  <= id_valid ? '{wb_en: id_wb_en, mem_r: id_mem_r,
                                        mem_w: id_mem_w, s: id_s} : '0;
            end
            if (w_status_load) begin
                r_status <= alu_sr;
            end
        end
    end

    fwd_mux u_fwd_val1 (
        .fwd_en     (1'b1),
        .src        (r_src1),
        .reg_val    (r_val1),
        .mem_wb_en  (mem_wb_en),
        .mem_dest   (mem_dest),
        .mem_result (mem_result),
        .wb_wb_en   (wb_wb_en),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .val        (val1)
    );

    // Immediates never come from the register file, so they are never forwarded
    fwd_mux u_fwd_val2 (
        .fwd_en     (~r_imm),
        .src        (r_src2),
        .reg_val    (r_val2),
        .mem_wb_en  (mem_wb_en),
        .mem_dest   (mem_dest),
        .mem_result (mem_result),
        .wb_wb_en   (wb_wb_en),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .val        (val2)
    );

    assign exe_valid = r_valid;
    assign exe_cmd   = r_cmd;
    assign exe_dest  = r_dest;
    assign exe_wb_en = r_ctrl.wb_en;
    assign exe_mem_r = r_ctrl.mem_r;
    assign exe_mem_w = r_ctrl.mem_w;
    assign status    = r_status;
    assign cin       = r_status[SR_C];

endmodule

`default_nettype wire

// File: tb/tb_exe_feed_reg.sv
// ============================================================================
// Module  : tb_exe_feed_reg
// Brief   : Self-checking bench for exe_feed_reg, scoreboard plus directed cases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_feed_reg;
    import exe_feed_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, freeze, flush, id_valid, id_s, id_imm;
    logic [3:0]  id_exe_cmd, id_src1, id_src2, id_dest;
    logic [31:0] id_val1, id_val2;
    logic        id_wb_en, id_mem_r, id_mem_w;
    logic        mem_wb_en, wb_wb_en;
    logic [3:0]  mem_dest, wb_dest, alu_sr;
    logic [31:0] mem_result, wb_value;
    logic        exe_valid, cin, exe_wb_en, exe_mem_r, exe_mem_w;
    logic [3:0]  exe_cmd, exe_dest, status;
    logic [31:0] val1, val2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        valid;
        logic        dc;
        logic [3:0]  cmd;
        logic        s, imm, wb, mr, mw;
        logic [31:0] v1, v2;
        logic [3:0]  s1, s2, dest;
        logic [3:0]  st;
    } exe_t;

    exe_t m;
    exe_t q[$];

    always #5 clk = ~clk;

    exe_feed_reg dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_exe_cmd(id_exe_cmd), .id_s(id_s), .id_imm(id_imm),
        .id_val1(id_val1), .id_val2(id_val2), .id_src1(id_src1), .id_src2(id_src2),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .alu_sr(alu_sr),
        .exe_valid(exe_valid), .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .cin(cin),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r(exe_mem_r),
        .exe_mem_w(exe_mem_w), .status(status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_fwd(input logic en, input logic [3:0] src,
                                            input logic [31:0] v);
        if (en && mem_wb_en && mem_dest == src) return mem_result;
        if (en && wb_wb_en && wb_dest == src) return wb_value;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic producers_off();
        mem_wb_en = 0; wb_wb_en = 0; mem_dest = 0; wb_dest = 0;
        mem_result = 0; wb_value = 0;
    endtask

    task automatic set_id(input logic v, input logic [3:0] cmd, input logic s,
                          input logic imm, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                          input logic wb);
        id_valid = v; id_exe_cmd = cmd; id_s = s; id_imm = imm;
        id_val1 = a; id_val2 = b; id_src1 = s1; id_src2 = s2; id_dest = d;
        id_wb_en = wb; id_mem_r = 0; id_mem_w = 0;
    endtask

    // Advance the reference model by one edge and queue the expected EXE state
    task automatic model_edge();
        if (m.valid && m.s && !freeze && !flush) m.st = alu_sr;
        if (flush) begin
            m.valid = 0; m.wb = 0; m.mr = 0; m.mw = 0; m.s = 0; m.dc = 1;
        end else if (!freeze) begin
            m.valid = id_valid; m.dc = 0; m.cmd = id_exe_cmd; m.imm = id_imm;
            m.v1 = id_val1; m.v2 = id_val2; m.s1 = id_src1; m.s2 = id_src2;
            m.dest = id_dest;
            m.wb = id_valid & id_wb_en; m.mr = id_valid & id_mem_r;
            m.mw = id_valid & id_mem_w; m.s = id_valid & id_s;
        end
        q.push_back(m);
    endtask

    task automatic compare_out();
        exe_t e;
        if (q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        check("sb_valid", {31'd0, exe_valid}, {31'd0, e.valid});
        check("sb_ctrl", {29'd0, exe_wb_en, exe_mem_r, exe_mem_w}, {29'd0, e.wb, e.mr, e.mw});
        check("sb_status", {28'd0, status}, {28'd0, e.st});
        check("sb_cin", {31'd0, cin}, {31'd0, e.st[SR_C]});
        if (!e.dc) begin
            check("sb_cmd", {28'd0, exe_cmd}, {28'd0, e.cmd});
            check("sb_dest", {28'd0, exe_dest}, {28'd0, e.dest});
            check("sb_val1", val1, exp_fwd(1'b1, e.s1, e.v1));
            check("sb_val2", val2, exp_fwd(!e.imm, e.s2, e.v2));
        end
    endtask

    initial begin
        rst_n = 0; freeze = 0; flush = 0; alu_sr = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        producers_off();
        #3;
        check("rst_valid", {31'd0, exe_valid}, 32'd0);
        check("rst_status", {28'd0, status}, 32'd0);
        check("rst_val1", val1, 32'd0);
        check("rst_val2", val2, 32'd0);
        check("rst_cin", {31'd0, cin}, 32'd0);
        #4 rst_n = 1;
        m = '{valid: 0, dc: 0, cmd: 0, s: 0, imm: 0, wb: 0, mr: 0, mw: 0,
              v1: 0, v2: 0, s1: 0, s2: 0, dest: 0, st: 0};
        step();

        // Random stream against the scoreboard, forwarding producers randomized
        for (int i = 0; i < 60; i++) begin
            set_id($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom), $urandom_range(0, 1));
            id_mem_r = $urandom_range(0, 1); id_mem_w = $urandom_range(0, 1);
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 6) == 0);
            alu_sr = 4'($urandom);
            model_edge();
            step();
            mem_wb_en = $urandom_range(0, 1); mem_dest = 4'($urandom_range(0, 3));
            mem_result = $urandom;
            wb_wb_en = $urandom_range(0, 1); wb_dest = 4'($urandom_range(0, 3));
            wb_value = $urandom;
            #1;
            compare_out();
        end
        freeze = 0; flush = 0; producers_off();

        // Double match on R3: MEM wins, then WB alone, then still live under freeze
        set_id(1, CMD_ADD, 0, 0, 32'h99, 32'h0, 4'd3, 4'd4, 4'd1, 1);
        step();
        mem_wb_en = 1; mem_dest = 3; mem_result = 32'h11;
        wb_wb_en = 1; wb_dest = 3; wb_value = 32'h22;
        #1 check("fwd_mem_over_wb", val1, 32'h11);
        mem_wb_en = 0;
        #1 check("fwd_wb_only", val1, 32'h22);
        wb_wb_en = 0;
        #1 check("fwd_none", val1, 32'h99);
        freeze = 1; mem_wb_en = 1;
        #1 check("fwd_in_freeze", val1, 32'h11);
        freeze = 0; producers_off();

        // Immediate operand ignores a matching producer
        set_id(1, CMD_MOV, 0, 1, 32'h0, 32'h5, 4'd0, 4'd7, 4'd2, 1);
        step();
        mem_wb_en = 1; mem_dest = 7; mem_result = 32'hDEAD;
        #1 check("imm_bypass", val2, 32'h5);
        producers_off();

        // Flag-setting SUBS: held under freeze, loaded when free
        set_id(1, CMD_SUB, 1, 0, 32'h8, 32'h8, 4'd5, 4'd6, 4'd5, 1);
        step();
        set_id(0, CMD_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        alu_sr = 4'b1100; freeze = 1;
        step();
        check("sr_frozen", {28'd0, status}, {28'd0, m.st});
        freeze = 0;
        step();
        check("sr_load", {28'd0, status}, 32'hC);
        check("sr_cin", {31'd0, cin}, 32'd1);

        // Flush during freeze squashes a flag-setting valid instruction
        set_id(1, CMD_SUB, 1, 0, 0, 0, 0, 0, 4'd3, 1);
        step();
        alu_sr = 4'b0011; freeze = 1; flush = 1;
        step();
        check("flush_valid", {31'd0, exe_valid}, 32'd0);
        check("flush_wb_en", {31'd0, exe_wb_en}, 32'd0);
        check("flush_status", {28'd0, status}, 32'hC);
        freeze = 0; flush = 0;

        // Stall hold across three edges while decode keeps changing
        set_id(1, CMD_ORR, 0, 0, 0, 0, 0, 0, 4'd9, 1);
        step();
        freeze = 1;
        for (int k = 0; k < 3; k++) begin
            set_id(1, 4'(k + 10), 0, 0, $urandom, $urandom, 0, 0, 4'(k + 1), 1);
            step();
            check("stall_cmd", {28'd0, exe_cmd}, {28'd0, CMD_ORR});
            check("stall_dest", {28'd0, exe_dest}, 32'd9);
        end
        freeze = 0;

        // Asynchronous reset mid-stream, with freeze and flush asserted
        set_id(1, CMD_SUB, 1, 0, 0, 0, 0, 0, 4'd4, 1);
        alu_sr = 4'b1010;
        step();
        step();
        check("pre_rst_status", {28'd0, status}, 32'hA);
        freeze = 1; flush = 1;
        #2 rst_n = 0;
        #1;
        check("arst_valid", {31'd0, exe_valid}, 32'd0);
        check("arst_status", {28'd0, status}, 32'd0);
        check("arst_cin", {31'd0, cin}, 32'd0);
        #3 rst_n = 1; freeze = 0; flush = 0;
        set_id(1, CMD_EOR, 0, 0, 32'h77, 0, 4'd2, 0, 4'd6, 1);
        step();
        check("post_rst_valid", {31'd0, exe_valid}, 32'd1);
        check("post_rst_cmd", {28'd0, exe_cmd}, {28'd0, CMD_EOR});
        check("post_rst_val1", val1, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/exe_feed_reg.md
EXE_FEED_REG -- requirements
Module: exe_feed_reg

Interface
REQ-001 The block SHALL expose these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- freeze  in  1  hazard stall; hold EXE contents.
- flush  in  1  branch taken; squash the instruction entering EXE.
- id_valid  in  1  decode stage presents a real instruction.
- id_exe_cmd  in  4  ALU command code.
- id_s  in  1  instruction updates status flags.
- id_imm  in  1  val2 is an immediate or shifted constant; no forwarding on val2.
- id_val1  in  32  Rn value read in decode.
- id_val2  in  32  operand-2 value from decode.
- id_src1, id_src2  in  4 each  register numbers of Rn and Rm.
- id_dest  in  4  destination register number.
- id_wb_en, id_mem_r, id_mem_w  in  1 each  control passed to later stages.
- mem_wb_en, mem_dest, mem_result  in  1/4/32  MEM-stage producer.
- wb_wb_en, wb_dest, wb_value  in  1/4/32  WB-stage producer.
- alu_sr  in  4  flags from the ALU, ordered {Z,C,N,V}.
- exe_valid  out  1  EXE holds a real instruction.
- exe_cmd  out  4  command to the ALU.
- val1, val2  out  32  forwarded ALU operands.
- cin  out  1  registered C flag, alu carry-in.
- exe_dest, exe_wb_en, exe_mem_r, exe_mem_w  out  4/1/1/1  registered control.
- status  out  4  architectural status register, {Z,C,N,V}.

Function
REQ-002 On each rising edge with flush=1, exe_valid SHALL become 0 and exe_wb_en, exe_mem_r, exe_mem_w, exe_s SHALL become 0; flush overrides freeze.
REQ-003 On each rising edge with flush=0 and freeze=1, all EXE registers SHALL hold their values.
REQ-004 On each rising edge with flush=0 and freeze=0, the EXE registers SHALL capture all id_* fields, and exe_valid SHALL capture id_valid.
REQ-005 When the captured id_valid is 0, the control bits (wb_en, mem_r, mem_w, s) SHALL be captured as 0.
REQ-006 Latency SHALL be one cycle from decode inputs to EXE outputs; no combinational path SHALL exist from id_* to any output.
REQ-007 The val1 source SHALL be selected by priority:
- mem_result, when mem_wb_en=1 and mem_dest equals the registered src1;
- otherwise wb_value, when wb_wb_en=1 and wb_dest equals the registered src1;
- otherwise the registered val1.
REQ-008 The val2 source SHALL use the same priority against the registered src2, applied only when the registered imm=0; when imm=1, val2 SHALL be the registered val2.
REQ-009 Forwarding SHALL be combinational from the registered EXE fields and the current producer inputs, and SHALL also operate while freeze=1.
REQ-010 The status register SHALL load alu_sr on a rising edge only when all of these hold: exe_valid=1, registered s=1, freeze=0, flush=0. Otherwise it SHALL hold.
REQ-011 A flush arriving in the same cycle as a flag-setting instruction in EXE SHALL NOT update status; the squash wins.
REQ-012 cin SHALL equal status[2], the C flag. status SHALL be output directly.
REQ-013 exe_cmd SHALL be a plain register copy; the block SHALL NOT decode or alter command codes.

Reset
REQ-014 While rst_n=0, every EXE register, exe_valid, and status SHALL be 0 immediately, independent of clk.
REQ-015 After reset, val1 and val2 SHALL be 0 unless a forwarding match exists against src 0; cin SHALL be 0.
REQ-016 When rst_n is asserted while freeze or flush is active, reset SHALL win. The first edge after release SHALL follow REQ-002..REQ-004 normally.

Structure
REQ-017 ALU command codes and the status bit indices (Z=3, C=2, N=1, V=0) SHALL live in the shared defines file. No local copies are permitted.
REQ-018 Operand selection SHALL be one sub-module, fwd_mux, instantiated twice, once for val1 and once for val2.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset mid-stream: drive rst_n=0 asynchronously -> exe_valid=0, status=4'b0000 before the next edge.
- MEM and WB both target R3: registered src1=3, mem_dest=3 with mem_result=32'h11, wb_dest=3 with wb_value=32'h22 -> val1=32'h11.
- Immediate bypass: id_imm=1, id_val2=32'h5, mem_dest=src2 -> val2=32'h5.
- Flag update: SUBS in EXE with alu_sr=4'b1100 and freeze=0 -> status=4'b1100 and cin=1 after the edge. The same instruction with freeze=1 -> status unchanged.
- Flush during freeze: flush=1 and freeze=1 with a valid EXE -> exe_valid=0 and exe_wb_en=0 after one edge; status unchanged.
- Stall hold: freeze=1 for 3 cycles while id_* changes -> exe_cmd and exe_dest remain at their pre-stall values throughout.
